// File: rtl/button_reader_pkg.sv
// button_reader_pkg: shared state encoding and counter sizing for the debounced button reader.
package button_reader_pkg;

    typedef enum logic [1:0] {
        RELEASED,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } btn_state_t;

    // Bits needed to hold values 0..max without wrapping.
    function automatic int cw(input int max);
        return max < 2 ? 1 : $clog2(max + 1);
    endfunction

endpackage

// File: rtl/button_reader_if.sv
// button_reader_if: raw pins in, debounced level and strobes out.
interface button_reader_if #(
    parameter int N = 4
);
    logic [N-1:0] BTN;
    logic [N-1:0] LEVEL;
    logic [N-1:0] PRESS;
    logic [N-1:0] RELEASE;
    logic [N-1:0] REPEAT;

    modport master (output BTN, input LEVEL, PRESS, RELEASE, REPEAT);
    modport slave (input BTN, output LEVEL, PRESS, RELEASE, REPEAT);
endinterface

// File: rtl/button_reader_channel.sv
// button_channel: synchronizer, debounce FSM and hold/repeat timer for one pressed-high pin.
module button_channel
    import button_reader_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 120000,
    parameter int HOLD_CYCLES     = 6000000,
    parameter int REPEAT_CYCLES   = 1200000
) (
    input  logic CLK,
    input  logic RST,
    input  logic pin,
    output logic level,
    output logic press,
    output logic rel,
    output logic rpt
);
    localparam int CW = cw(DEBOUNCE_CYCLES - 1);
    localparam int HW = cw(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] C_ONE = CW'(1);
    localparam logic [CW-1:0] C_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] H_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [HW-1:0] H_RELOAD = HW'(HOLD_CYCLES - REPEAT_CYCLES);

    btn_state_t state, state_n;
    logic [1:0] sync;
    logic [CW-1:0] cnt, cnt_n;
    logic [HW-1:0] hcnt, hcnt_n, hnext;
    logic level_n, press_n, rel_n, rpt_n, hit, s;

    assign s = sync[1];
    assign hit = hcnt == H_LAST;
    assign hnext = hit ? H_RELOAD : hcnt + HW'(1);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync <= '0;
            state <= RELEASED;
            cnt <= '0;
            hcnt <= '0;
            level <= 1'b0;
            press <= 1'b0;
            rel <= 1'b0;
            rpt <= 1'b0;
        end else begin
            sync <= {sync[0], pin};
            state <= state_n;
            cnt <= cnt_n;
            hcnt <= hcnt_n;
            level <= level_n;
            press <= press_n;
            rel <= rel_n;
            rpt <= rpt_n;
        end
    end

    // A bounce back into PRESSED counts as a held cycle, so only RELEASE_WAIT time is excluded.
    always_comb begin
        state_n = state;
        cnt_n = cnt;
        hcnt_n = hcnt;
        level_n = level;
        press_n = 1'b0;
        rel_n = 1'b0;
        rpt_n = 1'b0;
        case (state)
            RELEASED: begin
                if (s) begin
                    state_n = PRESS_WAIT;
                    cnt_n = C_ONE;
                end
            end
            PRESS_WAIT: begin
                if (!s) begin
                    state_n = RELEASED;
                end else if (cnt == C_LAST) begin
                    state_n = PRESSED;
                    level_n = 1'b1;
                    press_n = 1'b1;
                    hcnt_n = '0;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            PRESSED: begin
                if (!s) begin
                    state_n = RELEASE_WAIT;
                    cnt_n = C_ONE;
                end else begin
                    rpt_n = hit;
                    hcnt_n = hnext;
                end
            end
            RELEASE_WAIT: begin
                if (s) begin
                    state_n = PRESSED;
                    rpt_n = hit;
                    hcnt_n = hnext;
                end else if (cnt == C_LAST) begin
                    state_n = RELEASED;
                    level_n = 1'b0;
                    rel_n = 1'b1;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
        endcase
    end

endmodule

// File: rtl/button_reader.sv
// button_reader: N independent debounced buttons with level, press, release and auto-repeat outputs.
module button_reader
    import button_reader_pkg::*;
#(
    parameter int N               = 4,
    parameter int ACTIVE_LOW      = 1,
    parameter int DEBOUNCE_CYCLES = 120000,
    parameter int HOLD_CYCLES     = 6000000,
    parameter int REPEAT_CYCLES   = 1200000
) (
    input logic CLK,
    input logic RST,
    button_reader_if.slave bus
);
    // Normalizing before the synchronizer lets its reset value 0 mean "not pressed" for either polarity.
    for (genvar i = 0; i < N; i++) begin : g_ch
        button_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .HOLD_CYCLES(HOLD_CYCLES),
            .REPEAT_CYCLES(REPEAT_CYCLES)
        ) u_ch (
            .CLK(CLK),
            .RST(RST),
            .pin(bus.BTN[i] ^ (ACTIVE_LOW != 0)),
            .level(bus.LEVEL[i]),
            .press(bus.PRESS[i]),
            .rel(bus.RELEASE[i]),
            .rpt(bus.REPEAT[i])
        );
    end

endmodule
